// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter sharing two regfile write ports among NUM_REQ units
// Optional WB_ARB_PERF_EN adds saturating perf_grants / perf_conflicts counters.
module wb_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*5-1:0]     req_idx,
  input  logic [NUM_REQ*XLEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     write_en_1,
  output logic [4:0]               write_idx_1,
  output logic [XLEN-1:0]          write_data_1,
  output logic                     write_en_2,
  output logic [4:0]               write_idx_2,
  output logic [XLEN-1:0]          write_data_2
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]              perf_grants,
  output logic [15:0]              perf_conflicts
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W:0]   pos;
  logic [PTR_W-1:0] cur, g1_sel, g2_sel, last_sel;
  logic [PTR_W:0]   last_inc;
  logic             g1_found, g2_found, conflict;
  logic             grant_ok, g1_v, g2_v, conflict_v;
  logic [4:0]       g1_idx, g2_idx;
  logic [XLEN-1:0]  g1_data, g2_data;

  logic             wen1_q, wen1_d, wen2_q, wen2_d;
  logic [4:0]       widx1_q, widx1_d, widx2_q, widx2_d;
  logic [XLEN-1:0]  wdata1_q, wdata1_d, wdata2_q, wdata2_d;

  // Scan from rr_ptr; a candidate matching grant 1's index is skipped, not granted.
  always_comb begin
    g1_found = 1'b0;
    g2_found = 1'b0;
    g1_sel   = '0;
    g2_sel   = '0;
    conflict = 1'b0;
    pos      = '0;
    cur      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
      cur = pos[PTR_W-1:0];
      if (req_valid[cur]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1_sel   = cur;
        end else if (!g2_found) begin
          if (req_idx[int'(cur)*5 +: 5] != req_idx[int'(g1_sel)*5 +: 5]) begin
            g2_found = 1'b1;
            g2_sel   = cur;
          end else begin
            conflict = 1'b1;
          end
        end
      end
    end
  end

  assign grant_ok   = !reset && !flush;
  assign g1_v       = grant_ok && g1_found;
  assign g2_v       = grant_ok && g2_found;
  assign conflict_v = grant_ok && conflict;
  assign g1_idx     = req_idx[int'(g1_sel)*5 +: 5];
  assign g2_idx     = req_idx[int'(g2_sel)*5 +: 5];
  assign g1_data    = req_data[int'(g1_sel)*XLEN +: XLEN];
  assign g2_data    = req_data[int'(g2_sel)*XLEN +: XLEN];
  assign last_sel   = g2_v ? g2_sel : g1_sel;
  assign last_inc   = {1'b0, last_sel} + 1'b1;

  always_comb begin
    req_ready = '0;
    if (g1_v) req_ready[g1_sel] = 1'b1;
    if (g2_v) req_ready[g2_sel] = 1'b1;
  end

  // Index/data hold when a port is idle; x0 grants consume the request but never write.
  always_comb begin
    wen1_d   = 1'b0;
    wen2_d   = 1'b0;
    widx1_d  = widx1_q;
    widx2_d  = widx2_q;
    wdata1_d = wdata1_q;
    wdata2_d = wdata2_q;
    rr_ptr_d = rr_ptr_q;
    if (g1_v) begin
      wen1_d   = (g1_idx != 5'd0);
      widx1_d  = g1_idx;
      wdata1_d = g1_data;
      rr_ptr_d = (last_inc == (PTR_W+1)'(NUM_REQ)) ? '0 : last_inc[PTR_W-1:0];
    end
    if (g2_v) begin
      wen2_d   = (g2_idx != 5'd0);
      widx2_d  = g2_idx;
      wdata2_d = g2_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      wen1_q   <= 1'b0;
      wen2_q   <= 1'b0;
      widx1_q  <= '0;
      widx2_q  <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen1_q   <= wen1_d;
      wen2_q   <= wen2_d;
      widx1_q  <= widx1_d;
      widx2_q  <= widx2_d;
      wdata1_q <= wdata1_d;
      wdata2_q <= wdata2_d;
    end
  end

  assign write_en_1   = wen1_q;
  assign write_idx_1  = widx1_q;
  assign write_data_1 = wdata1_q;
  assign write_en_2   = wen2_q;
  assign write_idx_2  = widx2_q;
  assign write_data_2 = wdata2_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [15:0] perf_conflicts_q, perf_conflicts_d;
  logic [32:0] grants_sum;

  always_comb begin
    grants_sum       = {1'b0, perf_grants_q} + {31'b0, g1_v} + {31'b0, g2_v};
    perf_grants_d    = grants_sum[32] ? 32'hFFFF_FFFF : grants_sum[31:0];
    perf_conflicts_d = perf_conflicts_q;
    if (conflict_v && perf_conflicts_q != 16'hFFFF) perf_conflicts_d = perf_conflicts_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants_q    <= '0;
      perf_conflicts_q <= '0;
    end else begin
      perf_grants_q    <= perf_grants_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_grants    = perf_grants_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

  a_no_dup_write: assert property (@(posedge clock) disable iff (reset)
    !(write_en_1 && write_en_2) || (write_idx_1 != write_idx_2));

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_idx_known
    a_idx_known: assert property (@(posedge clock) disable iff (reset)
      !req_valid[i] || !$isunknown(req_idx[i*5 +: 5]));
  end

endmodule
